// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci XNOR LFSR random-number generator with range rejection and a bounded retry search.
// Ports: clk       - sole clock, rising edge
//        reset     - synchronous active-low reset
//        load      - load seed_in into the LFSR; aborts any request in flight
//        seed_in   - seed sampled when load=1
//        req       - request one number, sampled only in IDLE
//        busy      - a request is in progress (SEARCH or DONE)
//        valid     - one-cycle pulse, out holds a new result
//        out       - last delivered value, held between deliveries
//        timeout   - one-cycle pulse with valid when the retry budget ran out
//        lockup    - one-cycle pulse after an all-ones write was replaced by SEED
module lfsr_rng #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int unsigned      MAX_VAL   = 2**WIDTH-2,
    parameter int unsigned      MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] out,
    output logic             timeout,
    output logic             lockup
);
    localparam int unsigned      TW    = $clog2(MAX_TRIES) + 1;
    localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];
    localparam logic [TW-1:0]    LAST  = TW'(MAX_TRIES - 1);

    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "lfsr_rng: WIDTH must be 3..16");
    end
    if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
        $fatal(1, "lfsr_rng: SEED must not be all-ones");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $fatal(1, "lfsr_rng: MAX_TRIES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, out_q, out_d, step, wr_val;
    logic [TW-1:0]    tries_q, tries_d;
    logic             valid_q, valid_d, timeout_q, timeout_d, lockup_q, lockup_d;
    logic             accept, exhaust, in_search, finish, wr_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            tries_q   <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            lockup_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            tries_q   <= tries_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            lockup_q  <= lockup_d;
        end
    end

    always_comb begin
        step    = {lfsr_q[WIDTH-2:0], ~^(lfsr_q & TAPS)};
        accept  = step <= MAX_V;
        exhaust = tries_q == LAST;
        state_d = load                ? IDLE :
                  state_q == IDLE     ? (req ? SEARCH : IDLE) :
                  state_q == SEARCH   ? ((accept || exhaust) ? DONE : SEARCH) :
                                        IDLE;
    end

    // load wins over stepping; any all-ones write (seed or step) is diverted to SEED
    always_comb begin
        in_search = state_q == SEARCH && !load;
        finish    = in_search && (accept || exhaust);
        wr_en     = load || state_q == SEARCH;
        wr_val    = load ? seed_in : step;
        lockup_d  = wr_en && wr_val == {WIDTH{1'b1}};
        lfsr_d    = !wr_en ? lfsr_q : (lockup_d ? SEED : wr_val);
        tries_d   = state_q == IDLE ? '0 : in_search ? tries_q + 1'b1 : tries_q;
        out_d     = !finish ? out_q : (accept ? step : MAX_V);
        valid_d   = finish;
        timeout_d = finish && !accept;
    end

    always_comb begin
        busy    = state_q != IDLE;
        valid   = valid_q;
        out     = out_q;
        timeout = timeout_q;
        lockup  = lockup_q;
    end
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: randomized self-checking bench for lfsr_rng against an arithmetic reference model.
module tb_lfsr_rng;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_load, a_req, a_busy, a_valid, a_timeout, a_lockup;
    logic [7:0] a_seed, a_out;
    logic       b_reset, b_load, b_req, b_busy, b_valid, b_timeout, b_lockup;
    logic [7:0] b_seed, b_out;

    lfsr_rng u_a (
        .clk(clk), .reset(a_reset), .load(a_load), .seed_in(a_seed), .req(a_req),
        .busy(a_busy), .valid(a_valid), .out(a_out), .timeout(a_timeout), .lockup(a_lockup)
    );

    lfsr_rng #(.MAX_VAL(8'h0A), .MAX_TRIES(2)) u_b (
        .clk(clk), .reset(b_reset), .load(b_load), .seed_in(b_seed), .req(b_req),
        .busy(b_busy), .valid(b_valid), .out(b_out), .timeout(b_timeout), .lockup(b_lockup)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] ma, mb, mouta, moutb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one request = up to maxt steps, first stepped value <= maxv wins, else maxv with timeout
    task automatic m_request(inout logic [7:0] l, input int maxv, input int maxt,
                             output logic [7:0] o, output logic to, output int k);
        int nx;
        to = 1'b0;
        o  = 8'(maxv);
        k  = maxt;
        for (int i = 1; i <= maxt; i++) begin
            nx = (l * 2) % 256 + ((($countones(l & 8'hB8) % 2) == 0) ? 1 : 0);
            l  = (nx == 255) ? 8'd1 : 8'(nx);
            if (nx <= maxv) begin
                o = 8'(nx);
                k = i;
                return;
            end
        end
        to = 1'b1;
    endtask

    task automatic req_a(input bit noise, output logic [7:0] o, output logic to, output int lat);
        lat = -1; o = 'x; to = 'x;
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (noise) a_req = 1'($urandom);
            tick();
            if (a_valid) begin
                lat = i; o = a_out; to = a_timeout;
                break;
            end
        end
        a_req = 1'b0;
        tick();
    endtask

    task automatic req_b(input bit noise, output logic [7:0] o, output logic to, output int lat);
        lat = -1; o = 'x; to = 'x;
        b_req = 1'b1;
        tick();
        b_req = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (noise) b_req = 1'($urandom);
            tick();
            if (b_valid) begin
                lat = i; o = b_out; to = b_timeout;
                break;
            end
        end
        b_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        a_reset = 1'b0; a_load = 1'b1; a_seed = 8'hFF; a_req = 1'b1;
        b_reset = 1'b0; b_load = 1'b1; b_seed = 8'hFF; b_req = 1'b1;
        tick();
        n_tests++;
        if ({a_busy, a_valid, a_timeout, a_lockup, a_out} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_a outputs got %b/%b/%b/%b/%h need all zero", a_busy, a_valid, a_timeout, a_lockup, a_out);
        end
        n_tests++;
        if ({b_busy, b_valid, b_timeout, b_lockup, b_out} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_b outputs got %b/%b/%b/%b/%h need all zero", b_busy, b_valid, b_timeout, b_lockup, b_out);
        end
        a_reset = 1'b1; a_load = 1'b0; a_req = 1'b0;
        b_reset = 1'b1; b_load = 1'b0; b_req = 1'b0;
        tick();
        n_tests++;
        if ({a_busy, a_lockup, b_busy, b_lockup} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release got busy/lockup a=%b%b b=%b%b need 0000", a_busy, a_lockup, b_busy, b_lockup);
        end
        ma = 8'h01; mb = 8'h01; mouta = 8'h00; moutb = 8'h00;
    endtask

    task automatic test_basic();
        logic [7:0] mo; logic mto; int mk;
        m_request(ma, 254, 16, mo, mto, mk);
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        n_tests++;
        if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_search busy=%b valid=%b need busy=1 valid=0", a_busy, a_valid);
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b1 || a_out !== 8'h03 || a_timeout !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done valid=%b out=%h timeout=%b busy=%b need 1/03/0/1", a_valid, a_out, a_timeout, a_busy);
        end
        n_tests++;
        if (a_out !== mo) begin
            n_fail++;
            $display("FAIL basic_model out=%h model=%h", a_out, mo);
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_out !== 8'h03) begin
            n_fail++;
            $display("FAIL basic_after valid=%b busy=%b out=%h need 0/0/03", a_valid, a_busy, a_out);
        end
        mouta = mo;
    endtask

    task automatic test_small_range();
        logic [7:0] exp_o [3] = '{8'h03, 8'h07, 8'h0A};
        logic       exp_t [3] = '{1'b0, 1'b0, 1'b1};
        int         exp_k [3] = '{1, 1, 2};
        logic [7:0] o, mo; logic to, mto; int lat, mk;
        for (int i = 0; i < 3; i++) begin
            m_request(mb, 10, 2, mo, mto, mk);
            req_b(1'b0, o, to, lat);
            n_tests++;
            if (o !== exp_o[i] || to !== exp_t[i] || lat != exp_k[i]) begin
                n_fail++;
                $display("FAIL small_range[%0d] out=%h to=%b lat=%0d need %h/%b/%0d", i, o, to, lat, exp_o[i], exp_t[i], exp_k[i]);
            end
            moutb = mo;
        end
    endtask

    task automatic test_lockup();
        logic [7:0] o; logic to; int lat;
        a_load = 1'b1; a_seed = 8'hFF;
        tick();
        a_load = 1'b0;
        n_tests++;
        if (a_lockup !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_pulse lockup=%b busy=%b need 1/0", a_lockup, a_busy);
        end
        tick();
        n_tests++;
        if (a_lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_clear lockup=%b need 0", a_lockup);
        end
        ma = 8'h01;
        req_a(1'b0, o, to, lat);
        n_tests++;
        if (o !== 8'h03 || to !== 1'b0 || lat != 1) begin
            n_fail++;
            $display("FAIL lockup_recover out=%h to=%b lat=%0d need 03/0/1", o, to, lat);
        end
        ma = 8'h03; mouta = 8'h03;
    endtask

    task automatic test_load_abort();
        logic [7:0] o, mo, r; logic to, mto; int lat, mk;
        bit seen_valid;
        b_load = 1'b1; b_seed = 8'h1E;
        tick();
        b_load = 1'b0;
        b_req = 1'b1;
        tick();
        b_req = 1'b0;
        r = 8'($urandom);
        b_load = 1'b1; b_seed = r;
        tick();
        b_load = 1'b0;
        n_tests++;
        if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_timeout !== 1'b0 || b_out !== moutb) begin
            n_fail++;
            $display("FAIL load_abort busy=%b valid=%b to=%b out=%h need 0/0/0/%h", b_busy, b_valid, b_timeout, b_out, moutb);
        end
        n_tests++;
        if (b_lockup !== (r == 8'hFF)) begin
            n_fail++;
            $display("FAIL load_abort_lockup lockup=%b need %b", b_lockup, r == 8'hFF);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_valid |= b_valid | b_busy;
        end
        n_tests++;
        if (seen_valid) begin
            n_fail++;
            $display("FAIL load_abort_quiet activity after abort got 1 need 0");
        end
        mb = (r == 8'hFF) ? 8'h01 : r;
        m_request(mb, 10, 2, mo, mto, mk);
        req_b(1'b0, o, to, lat);
        n_tests++;
        if (o !== mo || to !== mto || lat != mk) begin
            n_fail++;
            $display("FAIL load_abort_next out=%h to=%b lat=%0d need %h/%b/%0d", o, to, lat, mo, mto, mk);
        end
        moutb = mo;
    endtask

    task automatic test_reset_mid();
        logic [7:0] o; logic to; int lat;
        a_req = 1'b1;
        tick();
        a_reset = 1'b0; a_load = 1'b1; a_seed = 8'h55;
        tick();
        n_tests++;
        if ({a_busy, a_valid, a_timeout, a_lockup, a_out} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid outputs %b/%b/%b/%b/%h need all zero", a_busy, a_valid, a_timeout, a_lockup, a_out);
        end
        a_reset = 1'b1; a_load = 1'b0; a_req = 1'b0;
        tick();
        ma = 8'h01;
        req_a(1'b0, o, to, lat);
        n_tests++;
        if (o !== 8'h03 || to !== 1'b0 || lat != 1) begin
            n_fail++;
            $display("FAIL reset_mid_next out=%h to=%b lat=%0d need 03/0/1", o, to, lat);
        end
        ma = 8'h03; mouta = 8'h03;
    endtask

    task automatic test_random();
        logic [7:0] o, mo, r; logic to, mto; int lat, mk, n;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                r = 8'($urandom);
                if ($urandom_range(7, 0) == 0) r = 8'hFF;
                b_load = 1'b1; b_seed = r;
                tick();
                b_load = 1'b0;
                n_tests++;
                if (b_lockup !== (r == 8'hFF)) begin
                    n_fail++;
                    $display("FAIL rand_load_lockup seed=%h lockup=%b need %b", r, b_lockup, r == 8'hFF);
                end
                mb = (r == 8'hFF) ? 8'h01 : r;
            end
            n = $urandom_range(3, 1);
            for (int j = 0; j < n; j++) begin
                m_request(mb, 10, 2, mo, mto, mk);
                req_b(1'b1, o, to, lat);
                n_tests++;
                if (o !== mo || to !== mto || lat != mk) begin
                    n_fail++;
                    $display("FAIL rand_b[%0d.%0d] out=%h to=%b lat=%0d need %h/%b/%0d", it, j, o, to, lat, mo, mto, mk);
                end
                moutb = mo;
            end
        end
        for (int it = 0; it < 8; it++) begin
            r = 8'($urandom);
            a_load = 1'b1; a_seed = r;
            tick();
            a_load = 1'b0;
            ma = (r == 8'hFF) ? 8'h01 : r;
            m_request(ma, 254, 16, mo, mto, mk);
            req_a(1'b1, o, to, lat);
            n_tests++;
            if (o !== mo || to !== mto || lat != mk) begin
                n_fail++;
                $display("FAIL rand_a[%0d] out=%h to=%b lat=%0d need %h/%b/%0d", it, o, to, lat, mo, mto, mk);
            end
            mouta = mo;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [256];
        int         cyc  [256];
        bit         seen [256];
        logic [7:0] mo; logic mto; int mk, cnt, dup;
        a_reset = 1'b0;
        tick();
        a_reset = 1'b1;
        ma = 8'h01;
        cnt = 0;
        a_req = 1'b1;
        for (int c = 0; c < 900 && cnt < 256; c++) begin
            tick();
            if (a_valid) begin
                vals[cnt] = a_out;
                cyc[cnt]  = c;
                cnt++;
            end
        end
        a_req = 1'b0;
        tick();
        tick();
        n_tests++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL b2b_count got %0d deliveries need 256", cnt);
        end else begin
            dup = 0;
            foreach (seen[i]) seen[i] = 1'b0;
            for (int i = 0; i < 255; i++) begin
                m_request(ma, 254, 16, mo, mto, mk);
                n_tests++;
                if (vals[i] !== mo) begin
                    n_fail++;
                    $display("FAIL b2b_value[%0d] got %h need %h", i, vals[i], mo);
                end
                if (seen[vals[i]] || vals[i] == 8'hFF) dup++;
                seen[vals[i]] = 1'b1;
            end
            n_tests++;
            if (dup != 0) begin
                n_fail++;
                $display("FAIL b2b_distinct got %0d repeats/all-ones need 0", dup);
            end
            n_tests++;
            if (vals[255] !== 8'h03) begin
                n_fail++;
                $display("FAIL b2b_wrap got %h need 03", vals[255]);
            end
            dup = 0;
            for (int i = 1; i < 256; i++) if (cyc[i] - cyc[i-1] != 3) dup++;
            n_tests++;
            if (dup != 0) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d gaps != 3 cycles need 0", dup);
            end
        end
    endtask

    initial begin
        a_reset = 1'b0; a_load = 1'b0; a_req = 1'b0; a_seed = 8'h00;
        b_reset = 1'b0; b_load = 1'b0; b_req = 1'b0; b_seed = 8'h00;
        tick();
        test_reset();
        test_basic();
        test_small_range();
        test_lockup();
        test_load_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
